// File: rtl/key_event_pkg.sv
// Shared types, default timings and helpers for the key event unit.
// Timings are in clock cycles; 10 ms debounce, 0.5 s long press, 0.1 s repeat.
package key_event_pkg;

   typedef enum logic [1:0] {
      KE_IDLE,
      KE_HELD,
      KE_LONG
   } ke_state_t;

   // 50 MHz system clock builds
   localparam int KE_DEB_50M    = 500_000;
   localparam int KE_LONG_50M   = 25_000_000;
   localparam int KE_REPEAT_50M = 5_000_000;

   // AUD_BCLK (3.072 MHz) builds
   localparam int KE_DEB_BCLK    = 30_720;
   localparam int KE_LONG_BCLK   = 1_536_000;
   localparam int KE_REPEAT_BCLK = 307_200;

   function automatic int ke_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_event_if.sv
// Key bundle between the board pushbuttons and the key event unit.
// The master side drives raw keys and repeat enables; the slave reports events.
interface key_event_if #(
   parameter int N_KEYS = 4
);

   logic [N_KEYS-1:0] i_keys;
   logic [N_KEYS-1:0] i_repeat_en;
   logic [N_KEYS-1:0] o_level;
   logic [N_KEYS-1:0] o_press;
   logic [N_KEYS-1:0] o_release;
   logic [N_KEYS-1:0] o_long;
   logic [N_KEYS-1:0] o_repeat;

   modport master (
      output i_keys,
      output i_repeat_en,
      input  o_level,
      input  o_press,
      input  o_release,
      input  o_long,
      input  o_repeat
   );

   modport slave (
      input  i_keys,
      input  i_repeat_en,
      output o_level,
      output o_press,
      output o_release,
      output o_long,
      output o_repeat
   );

endinterface

// File: rtl/key_event_channel.sv
// One key: 2-flop sync, debounce, press/release pulses,
// long-press detect and auto-repeat.
module key_event_channel
   import key_event_pkg::*;
#(
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int DEB_CYCLES    = 16,
   parameter int LONG_CYCLES   = 4096,
   parameter int REPEAT_CYCLES = 1024
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key,
   input  logic i_repeat_en,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);

   localparam int CNT_W =
      $clog2(ke_max3(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES) + 1);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic             lvl_q;
   logic [CNT_W-1:0] deb_cnt_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic [CNT_W-1:0] rep_cnt_q;
   ke_state_t        st_q;
   logic             press_q;
   logic             rel_q;
   logic             long_q;
   logic             rep_q;

   logic synced;
   logic mism;
   logic flip;

   assign synced = s2_q ^ ACTIVE_LOW;
   assign mism   = synced != lvl_q;
   assign flip   = mism && (deb_cnt_q == DEB_LAST);

   // Sync flops reset to the released level so no spurious edge after reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_q      <= ACTIVE_LOW;
         s2_q      <= ACTIVE_LOW;
         lvl_q     <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         s1_q <= i_key;
         s2_q <= s1_q;
         if (flip) begin
            lvl_q     <= ~lvl_q;
            deb_cnt_q <= '0;
         end else if (mism) begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
         end else begin
            deb_cnt_q <= '0;
         end
      end
   end

   // A release on the same edge as a long/repeat tick wins
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         st_q       <= KE_IDLE;
         hold_cnt_q <= '0;
         rep_cnt_q  <= '0;
         press_q    <= 1'b0;
         rel_q      <= 1'b0;
         long_q     <= 1'b0;
         rep_q      <= 1'b0;
      end else begin
         press_q <= flip && !lvl_q;
         rel_q   <= flip && lvl_q;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         unique case (st_q)
            KE_IDLE: begin
               if (flip && !lvl_q) begin
                  st_q       <= KE_HELD;
                  hold_cnt_q <= '0;
               end
            end
            KE_HELD: begin
               if (flip) begin
                  st_q <= KE_IDLE;
               end else if (hold_cnt_q == LONG_LAST) begin
                  st_q      <= KE_LONG;
                  long_q    <= 1'b1;
                  rep_cnt_q <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            KE_LONG: begin
               if (flip) begin
                  st_q <= KE_IDLE;
               end else if (rep_cnt_q == REP_LAST) begin
                  rep_cnt_q <= '0;
                  rep_q     <= i_repeat_en;
               end else begin
                  rep_cnt_q <= rep_cnt_q + 1'b1;
               end
            end
            default: st_q <= KE_IDLE;
         endcase
      end
   end

   assign o_level   = lvl_q;
   assign o_press   = press_q;
   assign o_release = rel_q;
   assign o_long    = long_q;
   assign o_repeat  = rep_q;

endmodule

// File: rtl/key_event_unit.sv
// N independent key channels between the pushbuttons and the menu FSM.
// Holding a key past the long-press time auto-repeats while enabled.
module key_event_unit
   import key_event_pkg::*;
#(
   parameter int N_KEYS        = 4,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int DEB_CYCLES    = 16,
   parameter int LONG_CYCLES   = 4096,
   parameter int REPEAT_CYCLES = 1024
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   key_event_if.slave   bus
);

   if (N_KEYS < 1) begin : g_bad_n
      $error("key_event_unit: N_KEYS must be >= 1");
   end
   if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("key_event_unit: DEB_CYCLES must be >= 2");
   end
   if (LONG_CYCLES < 1) begin : g_bad_long
      $error("key_event_unit: LONG_CYCLES must be >= 1");
   end
   if (REPEAT_CYCLES < 1) begin : g_bad_rep
      $error("key_event_unit: REPEAT_CYCLES must be >= 1");
   end

   logic [N_KEYS-1:0] level_w;
   logic [N_KEYS-1:0] press_w;
   logic [N_KEYS-1:0] rel_w;
   logic [N_KEYS-1:0] long_w;
   logic [N_KEYS-1:0] rep_w;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
      key_event_channel #(
         .ACTIVE_LOW    (ACTIVE_LOW),
         .DEB_CYCLES    (DEB_CYCLES),
         .LONG_CYCLES   (LONG_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_ch (
         .i_clk       (i_clk),
         .i_rst_n     (i_rst_n),
         .i_key       (bus.i_keys[k]),
         .i_repeat_en (bus.i_repeat_en[k]),
         .o_level     (level_w[k]),
         .o_press     (press_w[k]),
         .o_release   (rel_w[k]),
         .o_long      (long_w[k]),
         .o_repeat    (rep_w[k])
      );
   end

   assign bus.o_level   = level_w;
   assign bus.o_press   = press_w;
   assign bus.o_release = rel_w;
   assign bus.o_long    = long_w;
   assign bus.o_repeat  = rep_w;

endmodule

// File: tb/tb_key_event_unit.sv
// Scoreboard bench for key_event_unit: a window-based reference model
// predicts every output per edge; a negedge monitor pops and compares.
module tb_key_event_unit;

   localparam int NK   = 4;
   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int REP  = 8;

   typedef struct packed {
      logic [NK-1:0] level;
      logic [NK-1:0] press;
      logic [NK-1:0] rel;
      logic [NK-1:0] lng;
      logic [NK-1:0] rpt;
   } out_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   key_event_if #(.N_KEYS(NK)) bus ();

   key_event_unit #(
      .N_KEYS        (NK),
      .ACTIVE_LOW    (1'b1),
      .DEB_CYCLES    (DEB),
      .LONG_CYCLES   (LONG),
      .REPEAT_CYCLES (REP)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   out_t exp_q[$];
   out_t last_exp = '0;

   // Reference model state: history of pressed(=1) samples per key
   bit hist[NK][$];
   bit lvl[NK];
   int age[NK];

   int cnt_press[NK];
   int cnt_rel[NK];
   int cnt_long[NK];
   int cnt_rpt[NK];

   function automatic out_t dut_out();
      out_t o;
      o.level = bus.o_level;
      o.press = bus.o_press;
      o.rel   = bus.o_release;
      o.lng   = bus.o_long;
      o.rpt   = bus.o_repeat;
      return o;
   endfunction

   task automatic chk_int(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_out(input string name, input out_t act, input out_t exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s @%0t: got lvl=%b prs=%b rel=%b lng=%b rpt=%b expected lvl=%b prs=%b rel=%b lng=%b rpt=%b",
                    name, $time, act.level, act.press, act.rel, act.lng, act.rpt,
                    exp.level, exp.press, exp.rel, exp.lng, exp.rpt);
   endtask

   task automatic model_reset();
      for (int c = 0; c < NK; c++) begin
         hist[c].delete();
         for (int k = 0; k < DEB + 2; k++) hist[c].push_back(1'b0);
         lvl[c] = 1'b0;
         age[c] = 0;
      end
   endtask

   // Level becomes v once the DEB samples taken 2..DEB+1 edges ago all read v
   function automatic out_t model_step();
      out_t e;
      e = '0;
      for (int c = 0; c < NK; c++) begin
         bit tog;
         int sz;
         tog = 1'b1;
         hist[c].push_back(~bus.i_keys[c]);
         sz = hist[c].size();
         for (int k = sz - 2 - DEB; k <= sz - 3; k++)
            if (hist[c][k] == lvl[c]) tog = 1'b0;
         void'(hist[c].pop_front());
         if (tog) begin
            lvl[c] = ~lvl[c];
            if (lvl[c]) begin
               e.press[c] = 1'b1;
               age[c] = 0;
            end else begin
               e.rel[c] = 1'b1;
            end
         end else if (lvl[c]) begin
            age[c]++;
            if (age[c] == LONG) e.lng[c] = 1'b1;
            else if (age[c] > LONG && (age[c] - LONG) % REP == 0)
               e.rpt[c] = bus.i_repeat_en[c];
         end
         e.level[c] = lvl[c];
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
         exp_q.delete();
      end else begin
         exp_q.push_back(model_step());
      end
   end

   always @(negedge clk) begin
      out_t a;
      a = dut_out();
      if (!rst_n) begin
         last_exp = '0;
         chk_out("reset_outputs", a, '0);
      end else begin
         if (exp_q.size() > 0) last_exp = exp_q.pop_front();
         chk_out("scoreboard", a, last_exp);
         for (int c = 0; c < NK; c++) begin
            cnt_press[c] += int'(a.press[c]);
            cnt_rel[c]   += int'(a.rel[c]);
            cnt_long[c]  += int'(a.lng[c]);
            cnt_rpt[c]   += int'(a.rpt[c]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int p0, r0, l0, q0;
      for (int c = 0; c < NK; c++) begin
         cnt_press[c] = 0;
         cnt_rel[c]   = 0;
         cnt_long[c]  = 0;
         cnt_rpt[c]   = 0;
      end
      bus.i_keys      = 4'b0000;
      bus.i_repeat_en = 4'b0000;
      rst_n = 1'b0;
      tick(3);

      // All keys held through reset release: presses together
      rst_n = 1'b1;
      tick(10);
      bus.i_keys = 4'hF;
      tick(10);
      for (int c = 0; c < NK; c++) begin
         chk_int($sformatf("reset_press%0d", c), cnt_press[c], 1);
         chk_int($sformatf("reset_rel%0d", c), cnt_rel[c], 1);
      end

      // Clean press on key0
      p0 = cnt_press[0]; r0 = cnt_rel[0]; l0 = cnt_long[0];
      bus.i_keys = 4'hE;
      tick(40);
      bus.i_keys = 4'hF;
      tick(10);
      chk_int("clean_press0", cnt_press[0] - p0, 1);
      chk_int("clean_rel0", cnt_rel[0] - r0, 1);
      chk_int("clean_long0", cnt_long[0] - l0, 1);

      // Bounce on key1 shorter than the debounce window
      p0 = cnt_press[1];
      for (int i = 0; i < 15; i++) begin
         bus.i_keys = (i % 2 == 0) ? 4'hD : 4'hF;
         tick(2);
      end
      bus.i_keys = 4'hF;
      tick(10);
      chk_int("bounce_press1", cnt_press[1] - p0, 0);

      // Long press + repeat on key2; release coincides with a repeat slot
      p0 = cnt_press[2]; r0 = cnt_rel[2]; l0 = cnt_long[2]; q0 = cnt_rpt[2];
      bus.i_repeat_en = 4'h4;
      bus.i_keys = 4'hB;
      tick(52);
      bus.i_keys = 4'hF;
      tick(12);
      chk_int("longrep_press2", cnt_press[2] - p0, 1);
      chk_int("longrep_long2", cnt_long[2] - l0, 1);
      chk_int("longrep_rpt2", cnt_rpt[2] - q0, 3);
      chk_int("longrep_rel2", cnt_rel[2] - r0, 1);

      // Repeat disabled, re-enabled at edge 45
      q0 = cnt_rpt[2]; l0 = cnt_long[2];
      bus.i_repeat_en = 4'h0;
      bus.i_keys = 4'hB;
      tick(45);
      chk_int("repoff_rpt2", cnt_rpt[2] - q0, 0);
      bus.i_repeat_en = 4'h4;
      tick(7);
      bus.i_keys = 4'hF;
      tick(12);
      chk_int("repon_rpt2", cnt_rpt[2] - q0, 1);
      chk_int("repoff_long2", cnt_long[2] - l0, 1);

      // Random segments: glitches mixed with long holds
      for (int s = 0; s < 160; s++) begin
         bus.i_keys      = 4'($urandom());
         bus.i_repeat_en = 4'($urandom());
         if ($urandom_range(0, 3) == 0) tick($urandom_range(30, 60));
         else tick($urandom_range(1, 6));
      end
      bus.i_keys = 4'hF;
      bus.i_repeat_en = 4'h0;
      tick(40);

      // Reset while key3 is in long-press
      p0 = cnt_press[3]; r0 = cnt_rel[3];
      bus.i_repeat_en = 4'h8;
      bus.i_keys = 4'h7;
      tick(30);
      rst_n = 1'b0;
      tick(5);
      chk_int("midrst_rel3", cnt_rel[3] - r0, 0);
      rst_n = 1'b1;
      tick(10);
      chk_int("midrst_press3", cnt_press[3] - p0, 2);
      bus.i_keys = 4'hF;
      tick(12);
      chk_int("midrst_final_rel3", cnt_rel[3] - r0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
